// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encodings and access kinds.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic ACC_LW = 1'b0;
    localparam logic ACC_SW = 1'b1;

    function automatic logic is_word_aligned(input logic [1:0] byte_lsb);
        return byte_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/lsu_watchdog.sv
// Clearable cycle counter that flags the cycle whose increment reaches TIMEOUT-1.
module lsu_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && cnt_q != TERM)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Fires in the cycle that would bring the count to TIMEOUT-1, so the FSM
    // leaves REQ/WAIT after exactly TIMEOUT-1 cycles there.
    assign expired = en && !clr && ((cnt_q + CW'(1)) == TERM);

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: turns one CPU lw/sw into one word-aligned req/gnt/rvalid bus
// transaction, stalling the core until it completes or times out.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int          ADDR_W   = 30,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              stall_c, misaligned_c;
    logic              wd_clr, wd_en, wd_expired;

    lsu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        bus_err_d    = 1'b0;
        stall_c      = 1'b0;
        misaligned_c = 1'b0;
        wd_clr       = 1'b0;
        wd_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wd_clr = 1'b1;
                if (cpu_req) begin
                    if (is_word_aligned(cpu_addr[1:0])) begin
                        stall_c     = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr[ADDR_W+1:2];
                        mem_wdata_d = cpu_wdata;
                        state_d     = ST_REQ;
                    end else begin
                        misaligned_c = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                stall_c = 1'b1;
                wd_en   = 1'b1;
                // Completion is checked before expiry so a coinciding
                // grant/response still counts as a good transfer.
                if (mem_gnt && mem_we_q == ACC_SW) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (mem_gnt && mem_rvalid) begin
                    rdata_d   = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (wd_expired) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (mem_we_q == ACC_LW)
                        rdata_d = ERR_DATA;
                    state_d = ST_DONE;
                end else if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                wd_en   = 1'b1;
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end else if (wd_expired) begin
                    rdata_d   = ERR_DATA;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Combinational outputs are gated so the core sees no stall during reset.
    assign stall      = stall_c & ~reset;
    assign misaligned = misaligned_c & ~reset;
    assign cpu_rdata  = rdata_q;
    assign bus_err    = bus_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against a cycle-count model.
module tb_load_store_unit;

    localparam int          ADDR_W   = 30;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'h0000_0000;

    logic              clk;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              stall;
    logic              misaligned;
    logic              bus_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_rdata = 32'h0;

    load_store_unit #(
        .ADDR_W   (ADDR_W),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One CPU access. g = REQ cycles before grant, r = cycles from grant to
    // rvalid (0 = same cycle). stray injects ignorable rvalids before grant.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int g, input int r, input logic [31:0] resp, input logic stray);
        int          k, kc, exp_stall, exp_req;
        int          n_stall, n_req, n_err;
        logic        tmo, done, err_at_done;
        logic [31:0] exp_rd, rd_at_done;
        // Bus-busy cycles needed to finish; the unit gives up after TIMEOUT-1.
        k         = we ? g + 1 : g + 1 + r;
        tmo       = (k > TIMEOUT - 1);
        kc        = tmo ? TIMEOUT - 1 : k;
        exp_stall = 1 + kc;
        exp_req   = (g + 1 < kc) ? g + 1 : kc;
        exp_rd    = we ? model_rdata : (tmo ? ERR_DATA : resp);
        n_stall = 0; n_req = 0; n_err = 0;
        done = 1'b0; err_at_done = 1'b0; rd_at_done = 32'h0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = we;
                cpu_addr  = addr;
                cpu_wdata = wdata;
            end
            mem_gnt    = (c == 1 + g);
            mem_rvalid = (!we && c == 1 + g + r) || (stray && c >= 1 && c < 1 + g);
            mem_rdata  = (!we && c == 1 + g + r) ? resp : $urandom;
            #1;
            if (c == 1) begin
                chk("mem_addr", 32'(mem_addr), addr >> 2);
                chk("mem_we", 32'(mem_we), 32'(we));
                chk("mem_wdata", mem_wdata, wdata);
            end
            n_req += int'(mem_req);
            n_err += int'(bus_err);
            if (!stall) begin
                done        = 1'b1;
                err_at_done = bus_err;
                rd_at_done  = cpu_rdata;
            end else begin
                n_stall++;
            end
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("done_reached", 32'(done), 32'd1);
        chk("stall_cycles", 32'(n_stall), 32'(exp_stall));
        chk("mem_req_cycles", 32'(n_req), 32'(exp_req));
        chk("bus_err_cycles", 32'(n_err), 32'(tmo));
        chk("bus_err_done", 32'(err_at_done), 32'(tmo));
        chk("cpu_rdata_done", rd_at_done, exp_rd);
        model_rdata = exp_rd;
        $display("txn %s addr=0x%08h g=%0d r=%0d stall=%0d timeout=%0d rdata=0x%08h",
                 we ? "sw" : "lw", addr, g, r, n_stall, tmo, rd_at_done);
    endtask

    initial begin
        int          g, r;
        logic        we;
        logic [31:0] a;

        reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_outputs", {29'd0, misaligned, bus_err, mem_we}, 32'd0);
        chk("rst_mem_bus", 32'(mem_addr) | mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0; cpu_req = 1'b0;

        // lw 0xC: grant in first REQ cycle, data two cycles later.
        run_txn(1'b0, 32'h0000_000C, 32'h0, 0, 2, 32'h0000_03E7, 1'b0);
        // sw 0x10: grant withheld for three REQ cycles.
        run_txn(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 3, 0, 32'h0, 1'b0);

        // Misaligned load: one-cycle flag, no bus request, no stall.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0006; #1;
        chk("misaligned_pulse", 32'(misaligned), 32'd1);
        chk("misaligned_stall", 32'(stall), 32'd0);
        @(negedge clk);
        cpu_req = 1'b0; #1;
        chk("misaligned_clear", 32'(misaligned), 32'd0);
        chk("misaligned_no_req", 32'(mem_req), 32'd0);

        // Grant never arrives: timeout, then boundary cases at TIMEOUT-1.
        run_txn(1'b0, 32'h0000_0040, 32'h0, 100, 0, 32'h0, 1'b1);
        run_txn(1'b0, 32'h0000_0044, 32'h0, 13, 1, 32'h1357_9BDF, 1'b0);
        run_txn(1'b0, 32'h0000_0048, 32'h0, 14, 1, 32'h2468_ACE0, 1'b0);
        run_txn(1'b1, 32'h0000_004C, 32'h1111_2222, 14, 0, 32'h0, 1'b0);
        run_txn(1'b1, 32'h0000_0050, 32'h3333_4444, 15, 0, 32'h0, 1'b0);

        // Same-cycle grant and data, back to back.
        run_txn(1'b0, 32'h0000_0100, 32'h0, 0, 0, 32'h0000_0055, 1'b0);
        run_txn(1'b0, 32'h0000_0104, 32'h0, 0, 0, 32'h0000_0066, 1'b0);

        // Reset asserted while waiting for read data; late rvalid is dropped.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0200;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; #1;
        chk("wait_stall", 32'(stall), 32'd1);
        #1 reset = 1'b1; #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0; cpu_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        chk("late_rvalid_stall", 32'(stall), 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0; #1;
        chk("late_rvalid_rdata", cpu_rdata, 32'd0);
        chk("late_rvalid_req", 32'(mem_req), 32'd0);
        model_rdata = 32'h0;
        run_txn(1'b0, 32'h0000_0204, 32'h0, 0, 0, 32'h0000_1234, 1'b0);

        // Randomized mix of loads/stores and bus latencies.
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = $urandom & 32'hFFFF_FFFC;
            g  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 17)) : int'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 4));
            run_txn(we, a, $urandom, g, r, $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                cpu_req = 1'b0; #1;
                chk("idle_no_stall", 32'(stall), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory stage between the MIPS datapath (aluout/writedata/memwrite) and a multi-cycle data memory bus with req/gnt/rvalid handshake.
Replaces the zero-latency combinational dmem read path with a stalling interface.
Converts one CPU lw/sw per instruction into one word-aligned bus transaction. Holds the core through `stall` until the data returns or the write is granted.
Flags misaligned accesses and bus timeouts.

Parameters:
ADDR_W, 30, word-address width driven on mem_addr (byte address bits [ADDR_W+1:2])
TIMEOUT, 16, max cycles spent in REQ+WAIT before abort; must be >= 2
ERR_DATA, 32'h0000_0000, value returned on cpu_rdata after a timed-out load

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
cpu_req  in  1  memory instruction in execute; held high by the core while stall=1
cpu_we  in  1  1=sw, 0=lw; stable while cpu_req held
cpu_addr  in  32  byte address (aluout)
cpu_wdata  in  32  store data (writedata)
cpu_rdata  out  32  load result; valid in DONE cycle
stall  out  1  freeze pc/regfile write this cycle
misaligned  out  1  one-cycle pulse: cpu_addr[1:0]!=0 with cpu_req
bus_err  out  1  one-cycle pulse in DONE after timeout
mem_req  out  1  bus request, registered
mem_we  out  1  bus write enable, registered
mem_addr  out  ADDR_W  word address, registered
mem_wdata  out  32  write data, registered
mem_gnt  in  1  bus accepted request this cycle
mem_rvalid  in  1  read data valid this cycle
mem_rdata  in  32  read data

Behaviour:
- Reset value of every output is 0. While reset=1, stall is forced to 0 combinationally and state returns to IDLE asynchronously. mem_req therefore drops immediately on reset mid-transaction.
- States: IDLE, REQ, WAIT, DONE (encodings in package).
- IDLE:
  - cpu_req & aligned: stall=1 combinationally. Latch addr[ADDR_W+1:2], we and wdata into mem_* regs; set mem_req=1; go to REQ.
  - cpu_req & misaligned: misaligned=1, stall=0, no bus activity, stay in IDLE.
  - mem_rvalid/mem_gnt are ignored in IDLE, so stale responses after a reset are discarded.
- REQ: stall=1; mem_req held high with stable outputs until mem_gnt.
  - gnt & mem_we: clear mem_req and go to DONE. A write completes on grant.
  - gnt & !mem_we & mem_rvalid in the same cycle: capture mem_rdata and go to DONE.
  - gnt & !mem_we otherwise: clear mem_req and go to WAIT.
  - rvalid without gnt is ignored.
- WAIT: stall=1; on mem_rvalid capture mem_rdata into the data register and go to DONE.
- DONE: stall=0 and cpu_rdata = captured register; the core advances at the end of this cycle. Next state is always IDLE, regardless of cpu_req. Back-to-back memory instructions therefore cost at least 3 cycles each: IDLE, REQ, DONE.
- cpu_rdata holds its last value outside DONE. For stores it is left unchanged.
- Timeout:
  - Cycle counter cleared on IDLE->REQ, increments in REQ and WAIT.
  - Reaching TIMEOUT-1 without completion forces mem_req=0 and goes to DONE with data register = ERR_DATA (loads) and bus_err=1 for the DONE cycle.
  - If completion and timeout coincide, completion wins and bus_err=0.
- Latency: a load granted and answered immediately takes 3 cycles from cpu_req to DONE. Add one cycle per gnt wait and per rvalid wait.
- cpu_* inputs are sampled only in IDLE; changes while stalled are ignored.

Decomposition:
- Package lsu_pkg: state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3) and the access-type constants ACC_LW/ACC_SW.
- One sub-module, lsu_watchdog: a clearable up-counter with a TIMEOUT-1 terminal flag, parameter TIMEOUT, inputs clk/reset/clr/en, output expired.

Test Plan:
- lw 0x0000_000C, gnt in REQ cycle 1, rvalid 2 cycles later with 0x3E7 -> stall high 4 cycles; DONE cpu_rdata=0x3E7, mem_addr=3, mem_we=0.
- sw 0x10 with data 0xCAFEF00D, gnt held low 3 cycles -> mem_req stays high with mem_addr=4 and mem_wdata stable; DONE on the cycle after gnt; cpu_rdata unchanged.
- lw 0x0000_0006 -> misaligned=1 for one cycle, stall=0, mem_req never asserted.
- lw with TIMEOUT=16 and gnt never asserted -> mem_req drops after 15 REQ cycles; DONE with bus_err=1 and cpu_rdata=ERR_DATA.
- Read with gnt and rvalid in the same cycle (data 0x55) -> REQ goes directly to DONE with cpu_rdata=0x55; two back-to-back lw instructions each show exactly one DONE cycle and two transactions.
- Assert reset while in WAIT, then deliver rvalid after release -> mem_req and stall drop immediately, state is IDLE, the late rvalid is ignored and cpu_rdata=0.
